// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and the
// clocks-per-bit helper. Intended for reuse by a future uart_rx.
package uart_tx_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;  // start + data + stop

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer for the UART transmitter.
// A down-counter reloaded to Div-1 on every bit boundary (or on restart),
// so each bit lasts exactly Div clock cycles.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset, clears the counter
//   restart_i  reload the counter to start a fresh bit period next cycle
//   bit_end_o  high during the last cycle of the current bit period
module uart_tx_baud_gen #(
  parameter int unsigned Div = 347
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int unsigned   CntW   = $clog2(Div);
  localparam logic [CntW-1:0] Reload = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;

  assign bit_end_o = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (restart_i || bit_end_o) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so consecutive
// bytes leave with no idle gap between frames.
// Ports:
//   CLK       system clock, rising edge
//   RESET     asynchronous active-high reset; aborts any frame in flight
//   tx_data   byte to send, LSB first, sampled only on the accept edge
//   tx_valid  producer offers tx_data
//   tx_ready  byte accepted on an edge where tx_valid && tx_ready
//   TXD       serial line, idle high, registered
//   busy      high from start bit through stop bit
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 40_000_000,
  parameter int unsigned BAUD        = 115_200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TXD,
  output logic       busy
);

  localparam int unsigned DIV     = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int unsigned BitCntW = $clog2(UART_DATA_BITS);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(UART_DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx: DIV must be at least 2 clock cycles per bit");
  end

  if (UART_FRAME_BITS != UART_DATA_BITS + 2) begin : g_frame_check
    $error("uart_tx: frame must be start + data + stop bits");
  end

  uart_state_e               state_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] hold_q;
  logic                      hold_valid_q;
  logic [BitCntW-1:0]        bit_cnt_q;
  logic                      txd_q;
  logic                      busy_q;

  logic bit_end;
  logic accept;
  logic engine_free;
  logic restart;

  assign accept = tx_valid && !hold_valid_q;
  // The engine can take a byte directly when idle, or on the final stop-bit
  // cycle when nothing is waiting in the holding register.
  assign engine_free = (state_q == S_IDLE) ||
                       ((state_q == S_STOP) && bit_end && !hold_valid_q);
  // From idle the counter is free-running, so realign it to the new frame.
  assign restart = accept && (state_q == S_IDLE);

  assign tx_ready = !hold_valid_q;
  assign TXD      = txd_q;
  assign busy     = busy_q;

  uart_tx_baud_gen #(
    .Div (DIV)
  ) u_baud_gen (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .restart_i (restart),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      if (accept && !engine_free) begin
        hold_q       <= tx_data;
        hold_valid_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shift_q <= tx_data;
            state_q <= S_START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == LastBit) begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (hold_valid_q) begin
              // Drain the held byte: next start bit follows with no gap.
              shift_q      <= hold_q;
              hold_valid_q <= 1'b0;
              state_q      <= S_START;
              txd_q        <= 1'b0;
            end else if (accept) begin
              shift_q <= tx_data;
              state_q <= S_START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
